seg7_scan_controller: RTL and testbench

- Time-multiplexes one shared binary-to-7-segment decoder across N_DIGITS common-anode digits.
- Each digit slot has two phases: a guard phase with all anodes off (anti-ghosting), then a show phase with one anode on.
- Emits the current nibble to the decoder's 4-bit input (o_bits) and drives the active-low digit enables.
- New display values are committed only at frame boundaries, using a load/ack handshake, so the display never shows a partial update.

---
 rtl/seg7_pkg.sv | 16 +
 rtl/seg7_slot_timer.sv | 38 +++
 rtl/seg7_scan_controller.sv | 204 ++++++++++++++++++++
 tb/tb_seg7_scan_controller.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment scan controller.
// Anode enables are active-low, so the blank pattern is all ones.
package seg7_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GUARD,
        ST_SHOW
    } seg7_state_e;

    localparam int NIB_W = 4;

    // Wide enough for the largest supported digit count; sliced by users.
    localparam logic [7:0] ANODE_BLANK = 8'hFF;

endpackage

// File: rtl/seg7_slot_timer.sv
// Down-counter timing one guard or show phase of a digit slot.
// Loading L-1 makes the phase last L cycles; o_done flags the last one.
module seg7_slot_timer #(
    parameter int CW = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_load,
    input  logic          i_clear,
    input  logic [CW-1:0] i_count,
    output logic          o_done
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clear) begin
            cnt_d = '0;
        end else if (i_load) begin
            cnt_d = i_count;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_done = (cnt_q == '0);

endmodule

// File: rtl/seg7_scan_controller.sv
// Multiplexes one shared 7-segment decoder across N_DIGITS anodes.
// Build option SEG7_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seg7_scan_controller
    import seg7_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int TICK_DIV     = 50000,
    parameter int GUARD_CYCLES = 2
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_enable,
    input  logic [NIB_W*N_DIGITS-1:0]   i_value,
    input  logic                        i_load,
    output logic                        o_load_ack,
    output logic [NIB_W-1:0]            o_bits,
    output logic [N_DIGITS-1:0]         o_digit_sel_n,
    output logic                        o_frame_start
);

    localparam int VW = NIB_W * N_DIGITS;
    localparam int CW = $clog2(TICK_DIV + GUARD_CYCLES + 1);
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [N_DIGITS-1:0] BLANK   = ANODE_BLANK[N_DIGITS-1:0];
    localparam logic [IW-1:0]       LAST    = IW'(N_DIGITS - 1);
    localparam logic [CW-1:0]       SHOW_LD = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0]       GUARD_LD =
        (GUARD_CYCLES > 0) ? CW'(GUARD_CYCLES - 1) : '0;

    seg7_state_e           state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [VW-1:0]         disp_q, disp_d;
    logic [VW-1:0]         pval_q, pval_d;
    logic                  pend_q, pend_d;
    logic [NIB_W-1:0]      bits_q, bits_d;
    logic [N_DIGITS-1:0]   sel_q, sel_d;
    logic                  ack_q, ack_d;
    logic                  fs_q, fs_d;

    logic                  tmr_load;
    logic                  tmr_clear;
    logic [CW-1:0]         tmr_count;
    logic                  tmr_done;
    logic                  enter;
    logic                  drop;

    function automatic logic [NIB_W-1:0] nib(
        input logic [VW-1:0] v,
        input logic [IW-1:0] k
    );
        logic [VW-1:0] s;
        s = v >> (NIB_W * k);
        return s[NIB_W-1:0];
    endfunction

    function automatic logic [N_DIGITS-1:0] show_sel(
        input logic [IW-1:0] k,
        input logic [VW-1:0] v
    );
        logic [N_DIGITS-1:0] s;
        s    = BLANK;
        s[k] = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        // Digit k is a leading zero when it and everything above it is zero.
        if (k != '0 && (v >> (NIB_W * k)) == '0) begin
            s = BLANK;
        end
`endif
        return s;
    endfunction

    seg7_slot_timer #(
        .CW (CW)
    ) u_timer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (tmr_load),
        .i_clear (tmr_clear),
        .i_count (tmr_count),
        .o_done  (tmr_done)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        disp_d    = disp_q;
        pval_d    = pval_q;
        pend_d    = pend_q;
        bits_d    = bits_q;
        sel_d     = sel_q;
        ack_d     = 1'b0;
        fs_d      = 1'b0;
        tmr_load  = 1'b0;
        tmr_clear = 1'b0;
        tmr_count = '0;
        enter     = 1'b0;
        drop      = 1'b0;

        if (i_load) begin
            pval_d = i_value;
            pend_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                sel_d  = BLANK;
                bits_d = '0;
                if (pend_q) begin
                    disp_d = pval_q;
                    pend_d = i_load;
                    ack_d  = 1'b1;
                end
                if (i_enable) begin
                    idx_d = '0;
                    fs_d  = 1'b1;
                    enter = 1'b1;
                end
            end
            ST_GUARD: begin
                if (!i_enable) begin
                    drop = 1'b1;
                end else if (tmr_done) begin
                    state_d   = ST_SHOW;
                    sel_d     = show_sel(idx_q, disp_q);
                    tmr_load  = 1'b1;
                    tmr_count = SHOW_LD;
                end
            end
            ST_SHOW: begin
                if (!i_enable) begin
                    drop = 1'b1;
                end else if (tmr_done) begin
                    enter = 1'b1;
                    if (idx_q == LAST) begin
                        // Frame boundary: the only point a scan may commit.
                        idx_d = '0;
                        fs_d  = 1'b1;
                        if (pend_q) begin
                            disp_d = pval_q;
                            pend_d = i_load;
                            ack_d  = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: drop = 1'b1;
        endcase

        if (drop) begin
            state_d   = ST_IDLE;
            idx_d     = '0;
            tmr_clear = 1'b1;
            sel_d     = BLANK;
            bits_d    = '0;
        end

        if (enter) begin
            bits_d   = nib(disp_d, idx_d);
            tmr_load = 1'b1;
            if (GUARD_CYCLES > 0) begin
                state_d   = ST_GUARD;
                sel_d     = BLANK;
                tmr_count = GUARD_LD;
            end else begin
                state_d   = ST_SHOW;
                sel_d     = show_sel(idx_d, disp_d);
                tmr_count = SHOW_LD;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            disp_q  <= '0;
            pval_q  <= '0;
            pend_q  <= 1'b0;
            bits_q  <= '0;
            sel_q   <= BLANK;
            ack_q   <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            disp_q  <= disp_d;
            pval_q  <= pval_d;
            pend_q  <= pend_d;
            bits_q  <= bits_d;
            sel_q   <= sel_d;
            ack_q   <= ack_d;
            fs_q    <= fs_d;
        end
    end

    assign o_load_ack    = ack_q;
    assign o_bits        = bits_q;
    assign o_digit_sel_n = sel_q;
    assign o_frame_start = fs_q;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Randomized bench for seg7_scan_controller against a frame-position model.
// Default build: leading-zero blanking disabled.
module tb_seg7_scan_controller;

    localparam int N     = 4;
    localparam int T     = 4;
    localparam int G     = 1;
    localparam int SLOT  = T + G;
    localparam int FRAME = N * SLOT;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        en    = 1'b0;
    logic        ld    = 1'b0;
    logic [15:0] val   = '0;

    logic        ack;
    logic [3:0]  bits;
    logic [3:0]  sel;
    logic        fs;

    seg7_scan_controller #(
        .N_DIGITS     (N),
        .TICK_DIV     (T),
        .GUARD_CYCLES (G)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_enable      (en),
        .i_value       (val),
        .i_load        (ld),
        .o_load_ack    (ack),
        .o_bits        (bits),
        .o_digit_sel_n (sel),
        .o_frame_start (fs)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Model: scanning flag plus position within the frame.
    bit          m_scan;
    int          m_pos;
    logic [15:0] m_disp;
    logic [15:0] m_pval;
    bit          m_pend;
    bit          m_ack;
    bit          m_fs;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_scan = 0;
        m_pos  = 0;
        m_disp = '0;
        m_pval = '0;
        m_pend = 0;
        m_ack  = 0;
        m_fs   = 0;
    endtask

    task automatic model_step(input bit e, input bit l, input logic [15:0] v);
        m_ack = 0;
        m_fs  = 0;
        if (!m_scan) begin
            if (m_pend) begin
                m_disp = m_pval;
                m_pend = 0;
                m_ack  = 1;
            end
            if (e) begin
                m_scan = 1;
                m_pos  = 0;
                m_fs   = 1;
            end
        end else if (!e) begin
            m_scan = 0;
        end else begin
            m_pos = m_pos + 1;
            if (m_pos == FRAME) begin
                m_pos = 0;
                m_fs  = 1;
                if (m_pend) begin
                    m_disp = m_pval;
                    m_pend = 0;
                    m_ack  = 1;
                end
            end
        end
        if (l) begin
            m_pval = v;
            m_pend = 1;
        end
    endtask

    task automatic compare_all();
        int          slot;
        int          ph;
        logic [3:0]  es;
        logic [3:0]  eb;
        slot = m_pos / SLOT;
        ph   = m_pos % SLOT;
        es   = 4'hF;
        eb   = 4'h0;
        if (m_scan) begin
            eb = 4'((m_disp >> (4 * slot)) & 16'hF);
            if (ph >= G) es = ~(4'b0001 << slot);
        end
        check("sel", 32'(sel), 32'(es));
        check("bits", 32'(bits), 32'(eb));
        check("frame_start", 32'(fs), 32'(m_fs));
        check("load_ack", 32'(ack), 32'(m_ack));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sel"}, 32'(sel), 32'hF);
        check({tag, "_bits"}, 32'(bits), 32'h0);
        check({tag, "_fs"}, 32'(fs), 32'h0);
        check({tag, "_ack"}, 32'(ack), 32'h0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        for (int cyc = 0; cyc < 900; cyc++) begin
            @(negedge clk);
            if (!rst_n) rst_n = 1'b1;
            if (en) begin
                en = ($urandom_range(0, 99) >= 2);
            end else begin
                en = ($urandom_range(0, 99) < 25);
            end
            ld  = ($urandom_range(0, 99) < 8);
            val = 16'($urandom);
            if (cyc < 3) begin
                en = 1'b0;
                ld = (cyc == 1);
                val = 16'h1234;
            end
            if (cyc == 3) en = 1'b1;
            if (cyc == 499) begin
                en = 1'b1;
                ld = 1'b1;
            end

            @(posedge clk);
            model_step(en, ld, val);
            #1;
            compare_all();

            if (cyc == 499) begin
                // Asynchronous reset between edges discards the pending load.
                rst_n = 1'b0;
                #1;
                check_reset_outputs("async_rst");
                model_reset();
                ld = 1'b0;
                en = 1'b0;
                @(posedge clk);
                #1;
                check_reset_outputs("held_rst");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
